// File: rtl/clock_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
//   state_t     : 2-bit FSM encoding (IDLE / RUN / PAUSE / ALARM)
//   mmss_t      : packed BCD time, {min10, min1, sec10, sec1}
//   BCD_MAX9/5  : digit limits for the units digits and the tens digits
//   clamp_digit : saturate a preset digit to its limit
package clock_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
  } mmss_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction
endpackage

// File: rtl/mmss_down_counter.sv
// BCD MM:SS down-counter datapath.
//   clk, reset_n : clock, async active-low reset (clears to 00:00)
//   load         : take the clamped preset (wins over dec_en)
//   dec_en       : subtract one second; saturates at 00:00
//   preset       : raw BCD preset, clamped per digit here
//   cnt          : registered time
//   zero         : cnt is 00:00
//   one_left     : cnt is 00:01, i.e. the next decrement reaches zero
module mmss_down_counter
  import clock_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  logic  dec_en,
  input  mmss_t preset,
  output mmss_t cnt,
  output logic  zero,
  output logic  one_left
);
  mmss_t nxt;
  mmss_t clamped;

  assign zero     = (cnt == 16'h0000);
  assign one_left = (cnt == 16'h0001);

  always_comb begin
    clamped.min10 = clamp_digit(preset.min10, BCD_MAX5);
    clamped.min1  = clamp_digit(preset.min1,  BCD_MAX9);
    clamped.sec10 = clamp_digit(preset.sec10, BCD_MAX5);
    clamped.sec1  = clamp_digit(preset.sec1,  BCD_MAX9);
  end

  // Borrow ripples sec1 -> sec10 -> min1 -> min10. The !zero guard means
  // min10 is never decremented from 0.
  always_comb begin
    nxt = cnt;
    if (dec_en && !zero) begin
      if (cnt.sec1 != 4'd0) begin
        nxt.sec1 = cnt.sec1 - 4'd1;
      end else begin
        nxt.sec1 = BCD_MAX9;
        if (cnt.sec10 != 4'd0) begin
          nxt.sec10 = cnt.sec10 - 4'd1;
        end else begin
          nxt.sec10 = BCD_MAX5;
          if (cnt.min1 != 4'd0) begin
            nxt.min1 = cnt.min1 - 4'd1;
          end else begin
            nxt.min1  = BCD_MAX9;
            nxt.min10 = cnt.min10 - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= clamped;
    else           cnt <= nxt;
  end
endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer with run/pause and a self-clearing alarm.
//   clk, reset_n            : clock, async active-low reset
//   clk_sec                 : one-cycle 1 s tick
//   btn_load                : load clamped preset, go IDLE (highest priority)
//   btn_start               : run/pause toggle, alarm acknowledge
//   set_min10..set_sec1     : BCD preset
//   min10..sec1             : registered BCD remaining time
//   running / alarm         : registered state flags (RUN / ALARM)
module countdown_timer_mmss
  import clock_pkg::*;
#(
  parameter int ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_sec,
  input  logic       btn_load,
  input  logic       btn_start,
  input  logic [3:0] set_min10,
  input  logic [3:0] set_min1,
  input  logic [3:0] set_sec10,
  input  logic [3:0] set_sec1,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm
);
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

  state_t     state, state_nxt;
  logic [3:0] alarm_cnt;
  logic       running_d, alarm_d;
  logic       dec_en, zero, one_left;
  mmss_t      preset, cnt;

  assign preset = '{min10: set_min10, min1: set_min1, sec10: set_sec10, sec1: set_sec1};
  assign dec_en = (state == ST_RUN) && clk_sec && !btn_load;

  mmss_down_counter u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (btn_load),
    .dec_en   (dec_en),
    .preset   (preset),
    .cnt      (cnt),
    .zero     (zero),
    .one_left (one_left)
  );

  assign min10 = cnt.min10;
  assign min1  = cnt.min1;
  assign sec10 = cnt.sec10;
  assign sec1  = cnt.sec1;

  // State register plus the registered output flags, so running/alarm
  // change on the same edge as the state and the display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= running_d;
      alarm   <= alarm_d;
    end
  end

  // Next state. Reaching 00:00 beats a simultaneous pause request: there is
  // nothing left to pause.
  always_comb begin
    state_nxt = state;
    if (btn_load) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_PAUSE: if (btn_start && !zero) state_nxt = ST_RUN;
        ST_RUN: begin
          if (clk_sec && one_left) state_nxt = ST_ALARM;
          else if (btn_start)      state_nxt = ST_PAUSE;
        end
        ST_ALARM: begin
          if (btn_start)                              state_nxt = ST_IDLE;
          else if (clk_sec && alarm_cnt == ALARM_LAST) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state; registered above.
  always_comb begin
    running_d = (state_nxt == ST_RUN);
    alarm_d   = (state_nxt == ST_ALARM);
  end

  // Ticks seen while in ALARM; held at 0 elsewhere so each alarm starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          alarm_cnt <= '0;
    else if (btn_load || state != ST_ALARM) alarm_cnt <= '0;
    else if (clk_sec)                       alarm_cnt <= alarm_cnt + 4'd1;
  end
endmodule

// File: tb/tb_countdown_timer_mmss.sv
module tb_countdown_timer_mmss;
  localparam int ALARM_SEC = 5;

  logic clk = 1'b0, reset_n = 1'b1, clk_sec = 1'b0, btn_load = 1'b0, btn_start = 1'b0;
  logic [3:0] set_min10 = '0, set_min1 = '0, set_sec10 = '0, set_sec1 = '0;
  logic [3:0] min10, min1, sec10, sec1;
  logic running, alarm;
  logic [17:0] obs;

  countdown_timer_mmss #(.ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .reset_n(reset_n), .clk_sec(clk_sec), .btn_load(btn_load), .btn_start(btn_start),
    .set_min10(set_min10), .set_min1(set_min1), .set_sec10(set_sec10), .set_sec1(set_sec1),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;
  assign obs = {min10, min1, sec10, sec1, running, alarm};

  typedef struct { string tag; logic [17:0] val; } exp_t;
  exp_t sbq[$];
  int n_assert = 0, n_fail = 0;

  // Reference model: time kept as plain seconds, state as 0=IDLE 1=RUN 2=PAUSE 3=ALARM.
  int m_secs = 0, m_st = 0, m_acnt = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int m, c;
    m = s / 60; c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int clampi(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  task automatic model(input bit ld, input bit st, input bit tk);
    if (ld) begin
      m_secs = (clampi(set_min10, 5) * 10 + clampi(set_min1, 9)) * 60
             + clampi(set_sec10, 5) * 10 + clampi(set_sec1, 9);
      m_st = 0; m_acnt = 0;
    end else begin
      case (m_st)
        0, 2: if (st && m_secs != 0) m_st = 1;
        1: begin
          if (tk) begin
            m_secs--;
            if (m_secs == 0) begin m_st = 3; m_acnt = 0; end
            else if (st) m_st = 2;
          end else if (st) m_st = 2;
        end
        default: begin
          if (st) m_st = 0;
          else if (tk) begin
            if (m_acnt == ALARM_SEC - 1) begin m_st = 0; m_acnt = 0; end
            else m_acnt++;
          end
        end
      endcase
    end
  endtask

  function automatic logic [17:0] model_val();
    return {to_bcd(m_secs), m_st == 1, m_st == 3};
  endfunction

  task automatic check_const(input string tag, input logic [17:0] val);
    n_assert++;
    assert (obs === val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, val);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    if (sbq.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // One cycle of stimulus: drive at negedge, model + push, compare 1 ns after posedge.
  task automatic step(input string tag, input bit ld, input bit st, input bit tk);
    exp_t e;
    @(negedge clk);
    btn_load = ld; btn_start = st; clk_sec = tk;
    model(ld, st, tk);
    e.tag = tag; e.val = model_val();
    sbq.push_back(e);
    @(posedge clk); #1;
    btn_load = 1'b0; btn_start = 1'b0; clk_sec = 1'b0;
    check_sb();
  endtask

  task automatic set_time(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    set_min10 = a; set_min1 = b; set_sec10 = c; set_sec1 = d;
  endtask

  initial begin
    // Reset state, observed before any clock edge
    #2 reset_n = 1'b0;
    #1 check_const("reset_state", 18'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 00:03 countdown into ALARM
    set_time(0, 0, 0, 3);
    step("load_0003", 1, 0, 0);
    step("start_0003", 0, 1, 0);
    step("tick1_0002", 0, 0, 1);
    check_const("c_0002", {16'h0002, 2'b10});
    step("tick2_0001", 0, 0, 1);
    step("tick3_0000", 0, 0, 1);
    check_const("c_alarm", {16'h0000, 2'b01});

    // 10:00 borrow across all digits, then 60 more ticks
    set_time(1, 0, 0, 0);
    step("load_1000", 1, 0, 0);
    step("start_1000", 0, 1, 0);
    step("tick_0959", 0, 0, 1);
    check_const("c_0959", {16'h0959, 2'b10});
    for (int i = 0; i < 60; i++) step("tick_run", 0, 0, 1);
    check_const("c_0859", {16'h0859, 2'b10});

    // Pause coinciding with a tick
    set_time(0, 0, 0, 5);
    step("load_0005", 1, 0, 0);
    step("start_0005", 0, 1, 0);
    step("tick_0004", 0, 0, 1);
    step("tick_0003", 0, 0, 1);
    step("tick_start", 0, 1, 1);
    check_const("c_pause_0002", {16'h0002, 2'b00});
    for (int i = 0; i < 4; i++) step("pause_tick", 0, 0, 1);
    step("resume", 0, 1, 0);
    step("pause_again", 0, 1, 0);

    // Clamping and start at 00:00
    set_time(9, 15, 7, 12);
    step("load_clamp", 1, 0, 0);
    check_const("c_5959", {16'h5959, 2'b00});
    set_time(0, 0, 0, 0);
    step("load_0000", 1, 0, 0);
    step("start_zero", 0, 1, 0);
    step("tick_idle", 0, 0, 1);

    // Alarm self-clear after ALARM_SEC ticks
    set_time(0, 0, 0, 1);
    step("load_0001", 1, 0, 0);
    step("start_0001", 0, 1, 0);
    step("tick_to_alarm", 0, 0, 1);
    for (int i = 0; i < ALARM_SEC - 1; i++) step("alarm_tick", 0, 0, 1);
    check_const("c_alarm_held", {16'h0000, 2'b01});
    step("alarm_last", 0, 0, 1);
    check_const("c_alarm_clear", {16'h0000, 2'b00});

    // Alarm acknowledged by btn_start
    step("load_0001b", 1, 0, 0);
    step("start_0001b", 0, 1, 0);
    step("tick_alarm_b", 0, 0, 1);
    step("alarm_tick_b1", 0, 0, 1);
    step("alarm_tick_b2", 0, 0, 1);
    step("alarm_ack", 0, 1, 0);
    check_const("c_ack", {16'h0000, 2'b00});

    // Load during RUN has priority over tick
    set_time(0, 2, 0, 0);
    step("load_0200", 1, 0, 0);
    step("start_0200", 0, 1, 0);
    step("load_over_tick", 1, 0, 1);

    // Async reset mid-RUN at 03:17
    set_time(0, 3, 2, 0);
    step("load_0320", 1, 0, 0);
    step("start_0320", 0, 1, 0);
    for (int i = 0; i < 3; i++) step("tick_to_0317", 0, 0, 1);
    check_const("c_0317", {16'h0317, 2'b10});
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_const("async_reset", 18'h0);
    m_secs = 0; m_st = 0; m_acnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset_tick1", 0, 0, 1);
    step("post_reset_tick2", 0, 0, 1);
    step("post_reset_start", 0, 1, 0);
    check_const("c_post_reset", 18'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
